// File: rtl/instr_fetch_queue.sv
// Purpose : fetch stage - owns the PC, issues one imem request at a time and
//           buffers returned words in a DEPTH-entry FIFO feeding decode.
// Latency : imem_rvalid in cycle t -> out_valid/fields visible in cycle t+1.
// Backpres: out_ready low lets the FIFO fill; requests stop when
//           occupancy + outstanding == DEPTH.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   fetch_en                    allow new imem requests
//   redirect_valid/redirect_pc  flush FIFO and load new PC (bits[1:0] dropped)
//   imem_req/imem_addr          request (always accepted), address = pc
//   imem_rvalid/imem_rdata      in-order response, >=1 cycle after request
//   out_valid/out_ready         decode handshake on the FIFO head
//   out_pc, A1, A2, A3, OP, funct3, funct7, Imm, funct77
//                               head PC and instruction fields (0 when empty)
//   illegal                     only with IFQ_ILLEGAL_DETECT_EN defined:
//                               head present and not a recognised RV32 opcode
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  output logic [4:0]      A3,
  output logic [6:0]      OP,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [24:0]     Imm,
`ifdef IFQ_ILLEGAL_DETECT_EN
  output logic            illegal,
`endif
  output logic [6:0]      funct77
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t          state_q,  state_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;   // address of the outstanding request
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;    // FIFO occupancy
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];

  logic            pop_ok;
  logic            push;
  logic            pop;
  logic [CW-1:0]   cnt_after;
  entry_t          head;

  assign out_valid = (count_q != '0);
  assign pop_ok    = out_valid && out_ready;
  assign imem_addr = pc_q;

  // Occupancy once this cycle's response lands and any pop retires;
  // a re-issue must leave room for its own reserved slot.
  assign cnt_after = count_q + CW'(1) - CW'(pop_ok);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    imem_req = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;

    if (redirect_valid) begin
      // Flush wins over everything: no push, no pop, no request.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_pc & PC_MASK;
      unique case (state_q)
        FETCH:   state_d = FETCH;
        // A response still in flight must be swallowed when it arrives.
        WAIT:    state_d = imem_rvalid ? FETCH : DROP;
        DROP:    state_d = imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      pop = pop_ok;
      unique case (state_q)
        FETCH: begin
          if (fetch_en && (count_q < DEPTH_C)) begin
            imem_req = 1'b1;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push = 1'b1;
            if (fetch_en && (cnt_after < DEPTH_C)) begin
              imem_req = 1'b1;
              state_d  = WAIT;
            end else begin
              state_d  = FETCH;
            end
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase

      if (imem_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
      end

      if (push) begin
        mem_d[wr_ptr_q] = '{pc: req_pc_q, instr: imem_rdata};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // ------------------------------------------------------------------
  // Decode view of the head; forced to zero while the FIFO is empty so
  // stale entries never leak to decode.
  // ------------------------------------------------------------------
  assign head    = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc  = head.pc;
  assign A1      = head.instr[19:15];
  assign A2      = head.instr[24:20];
  assign A3      = head.instr[11:7];
  assign OP      = head.instr[6:0];
  assign funct3  = head.instr[14:12];
  assign funct7  = head.instr[30];
  assign Imm     = head.instr[31:7];
  assign funct77 = head.instr[31:25];

`ifdef IFQ_ILLEGAL_DETECT_EN
  logic op_known;

  always_comb begin
    op_known = 1'b0;
    case (head.instr[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b1110011, 7'b0001111: op_known = 1'b1;
      default:                            op_known = 1'b0;
    endcase
  end

  // Compressed/short encodings (low bits != 11) are rejected as well.
  assign illegal = out_valid && ((head.instr[1:0] != 2'b11) || !op_known);
`endif

endmodule
